// File: rtl/lsu64_mem_port.sv
// MEM-stage load/store responder: checks alignment, drives a doubleword
// req/ready memory bus with byte strobes, and returns extended load data.
module lsu64_mem_port #(
  parameter int unsigned ADDR_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [2:0]        dm_rd_ctrl,
  input  logic [2:0]        dm_wr_ctrl,
  input  logic [ADDR_W-1:0] addr,
  input  logic [63:0]       wdata,
  output logic              stall,
  output logic              done,
  output logic [63:0]       rdata,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [63:0]       mem_wdata,
  output logic [7:0]        mem_wstrb,
  input  logic              mem_ready,
  input  logic [63:0]       mem_rdata
);

  localparam int unsigned DATA_W = 64;
  localparam int unsigned STRB_W = 8;

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t              state, state_d;
  logic                done_d, err_d, mem_req_d, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_d, rdata_d;
  logic [STRB_W-1:0]   mem_wstrb_d;
  logic [2:0]          ld_code, ld_code_d;
  logic [2:0]          ld_off, ld_off_d;

  logic                rd_any, wr_any, code_ok, aligned, start, bad;
  logic [1:0]          size;
  logic [2:0]          off;
  logic [DATA_W-1:0]   st_wdata;
  logic [STRB_W-1:0]   st_wstrb;
  logic [DATA_W-1:0]   shifted, ld_ext;

  assign off = addr[2:0];

  // Decode the request: access size, code legality and alignment
  always_comb begin
    rd_any  = |dm_rd_ctrl;
    wr_any  = |dm_wr_ctrl;
    size    = 2'd0;
    code_ok = 1'b0;
    if (rd_any && !wr_any) begin
      case (dm_rd_ctrl)
        3'b001, 3'b010: begin size = 2'd0; code_ok = 1'b1; end
        3'b011, 3'b100: begin size = 2'd1; code_ok = 1'b1; end
        3'b101:         begin size = 2'd2; code_ok = 1'b1; end
        3'b110:         begin size = 2'd3; code_ok = 1'b1; end
        default:        code_ok = 1'b0;
      endcase
    end else if (wr_any && !rd_any) begin
      case (dm_wr_ctrl)
        3'b001:  begin size = 2'd0; code_ok = 1'b1; end
        3'b010:  begin size = 2'd1; code_ok = 1'b1; end
        3'b011:  begin size = 2'd2; code_ok = 1'b1; end
        3'b100:  begin size = 2'd3; code_ok = 1'b1; end
        default: code_ok = 1'b0;
      endcase
    end
    case (size)
      2'd0:    aligned = 1'b1;
      2'd1:    aligned = ~off[0];
      2'd2:    aligned = (off[1:0] == 2'b00);
      default: aligned = (off == 3'b000);
    endcase
    // code_ok already implies exactly one of the two controls is active
    start = req_valid & code_ok & aligned;
    bad   = req_valid & (rd_any | wr_any) & ~start;
  end

  // Replicate store data across lanes and place the byte strobes
  always_comb begin
    st_wdata = wdata;
    st_wstrb = 8'hFF;
    case (dm_wr_ctrl)
      3'b001: begin st_wdata = {8{wdata[7:0]}};  st_wstrb = 8'h01 << off; end
      3'b010: begin st_wdata = {4{wdata[15:0]}}; st_wstrb = 8'h03 << off; end
      3'b011: begin st_wdata = {2{wdata[31:0]}}; st_wstrb = 8'h0F << off; end
      default: begin st_wdata = wdata;            st_wstrb = 8'hFF;        end
    endcase
  end

  // Align returned doubleword to the requested byte and extend
  always_comb begin
    shifted = mem_rdata >> {ld_off, 3'b000};
    case (ld_code)
      3'b001:  ld_ext = {{56{shifted[7]}}, shifted[7:0]};
      3'b010:  ld_ext = {56'd0, shifted[7:0]};
      3'b011:  ld_ext = {{48{shifted[15]}}, shifted[15:0]};
      3'b100:  ld_ext = {48'd0, shifted[15:0]};
      3'b101:  ld_ext = {{32{shifted[31]}}, shifted[31:0]};
      default: ld_ext = shifted;
    endcase
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state;
    stall       = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    mem_req_d   = mem_req;
    mem_we_d    = mem_we;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    mem_wstrb_d = mem_wstrb;
    rdata_d     = rdata;
    ld_code_d   = ld_code;
    ld_off_d    = ld_off;
    case (state)
      IDLE: begin
        if (start) begin
          stall       = 1'b1;
          state_d     = REQ;
          mem_req_d   = 1'b1;
          mem_we_d    = wr_any;
          mem_addr_d  = {addr[ADDR_W-1:3], 3'b000};
          mem_wdata_d = wr_any ? st_wdata : '0;
          mem_wstrb_d = wr_any ? st_wstrb : '0;
          ld_code_d   = dm_rd_ctrl;
          ld_off_d    = off;
        end else if (bad) begin
          err_d = 1'b1;
        end
      end
      REQ: begin
        stall = 1'b1;
        if (mem_ready) begin
          state_d   = RESP;
          mem_req_d = 1'b0;
          done_d    = 1'b1;
          if (ld_code != 3'b000) rdata_d = ld_ext;
        end
      end
      RESP: begin
        // Pipeline advances on this edge; any new request is not sampled here
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      done      <= 1'b0;
      err       <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      rdata     <= '0;
      ld_code   <= 3'b000;
      ld_off    <= 3'b000;
    end else begin
      state     <= state_d;
      done      <= done_d;
      err       <= err_d;
      mem_req   <= mem_req_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      mem_wstrb <= mem_wstrb_d;
      rdata     <= rdata_d;
      ld_code   <= ld_code_d;
      ld_off    <= ld_off_d;
    end
  end

endmodule

// File: tb/tb_lsu64_mem_port.sv
// Bench for lsu64_mem_port: vector table plus reset-mid-access sequence.
module tb_lsu64_mem_port;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [2:0]  dm_rd_ctrl, dm_wr_ctrl;
  logic [63:0] addr, wdata;
  logic        stall, done, err, mem_req, mem_we, mem_ready;
  logic [63:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_wstrb;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] exp_q[$];

  typedef struct {
    logic [2:0]  rd;
    logic [2:0]  wr;
    logic [63:0] a;
    logic [63:0] wd;
    logic [63:0] mrd;
    int          waits;
    logic        e_err;
    logic [63:0] e_addr;
    logic [7:0]  e_strb;
    logic [63:0] e_wdata;
    logic [63:0] e_rdata;
  } vec_t;

  vec_t vecs[$];

  lsu64_mem_port #(.ADDR_W(64)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid),
    .dm_rd_ctrl(dm_rd_ctrl), .dm_wr_ctrl(dm_wr_ctrl),
    .addr(addr), .wdata(wdata), .stall(stall), .done(done),
    .rdata(rdata), .err(err), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic [2:0] rd, input logic [2:0] wr, input logic [63:0] a,
                     input logic [63:0] wd, input logic [63:0] mrd, input int waits,
                     input logic e_err, input logic [7:0] e_strb,
                     input logic [63:0] e_wdata, input logic [63:0] e_rdata);
    vec_t v;
    v.rd = rd; v.wr = wr; v.a = a; v.wd = wd; v.mrd = mrd; v.waits = waits;
    v.e_err = e_err; v.e_addr = {a[63:3], 3'b000}; v.e_strb = e_strb;
    v.e_wdata = e_wdata; v.e_rdata = e_rdata;
    vecs.push_back(v);
  endtask

  task automatic idle_inputs();
    req_valid  = 1'b0;
    dm_rd_ctrl = 3'b000;
    dm_wr_ctrl = 3'b000;
  endtask

  // Drive one request starting at posedge+1 with the DUT idle; check until it retires
  task automatic run_vec(input vec_t v);
    int  stall_cnt;
    int  w;
    bit  seen;
    bit  is_st;
    is_st      = (v.wr != 3'b000) && (v.rd == 3'b000);
    req_valid  = 1'b1;
    dm_rd_ctrl = v.rd;
    dm_wr_ctrl = v.wr;
    addr       = v.a;
    wdata      = v.wd;
    mem_rdata  = 64'hDEAD_DEAD_DEAD_DEAD;
    mem_ready  = 1'b1;
    #1;
    if (v.e_err) begin
      chk("err_accept_stall", 64'(stall), 64'd0);
      @(posedge clk); #1;
      idle_inputs();
      chk("err_pulse", 64'(err), 64'd1);
      chk("err_no_req", 64'(mem_req), 64'd0);
      chk("err_stall", 64'(stall), 64'd0);
      @(posedge clk); #1;
      chk("err_once", 64'(err), 64'd0);
      chk("err_no_req2", 64'(mem_req), 64'd0);
      chk("err_rdata_kept", rdata, v.e_rdata);
      return;
    end
    chk("accept_stall", 64'(stall), 64'd1);
    stall_cnt = 1;
    exp_q.push_back(v.e_rdata);
    @(posedge clk); #1;
    idle_inputs();
    addr  = ~v.a;
    wdata = ~v.wd;
    w     = 0;
    seen  = 1'b0;
    for (int cyc = 0; cyc < 32 && !seen; cyc++) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        chk("req_mem_req", 64'(mem_req), 64'd1);
        chk("req_stall", 64'(stall), 64'd1);
        chk("req_addr", mem_addr, v.e_addr);
        chk("req_we", 64'(mem_we), 64'(is_st));
        chk("req_wstrb", 64'(mem_wstrb), 64'(v.e_strb));
        if (is_st) chk("req_wdata", mem_wdata, v.e_wdata);
        if (stall) stall_cnt++;
        mem_ready = (w >= v.waits);
        mem_rdata = mem_ready ? v.mrd : 64'hA5A5_5A5A_A5A5_5A5A;
        w++;
        @(posedge clk); #1;
      end
    end
    if (!seen) begin
      chk("done_timeout", 64'd0, 64'd1);
      return;
    end
    mem_ready = 1'b0;
    chk("resp_stall", 64'(stall), 64'd0);
    chk("resp_mem_req", 64'(mem_req), 64'd0);
    chk("resp_err", 64'(err), 64'd0);
    chk("stall_cycles", 64'(stall_cnt), 64'(v.waits + 2));
    if (exp_q.size() == 0) chk("scoreboard_empty", 64'd0, 64'd1);
    else                   chk("rdata", rdata, exp_q.pop_front());
    @(posedge clk); #1;
    chk("done_once", 64'(done), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // rd: lb=1 lbu=2 lh=3 lhu=4 lw=5 ld=6; wr: sb=1 sh=2 sw=3 sd=4
    add(3'd1, 3'd0, 64'h1007, 64'h0, 64'h8877665544332211, 0, 1'b0, 8'h00, 64'h0, 64'hFFFFFFFFFFFFFF88);
    add(3'd2, 3'd0, 64'h1007, 64'h0, 64'h8877665544332211, 0, 1'b0, 8'h00, 64'h0, 64'h0000000000000088);
    add(3'd5, 3'd0, 64'h1004, 64'h0, 64'h8877665544332211, 0, 1'b0, 8'h00, 64'h0, 64'hFFFFFFFF88776655);
    add(3'd6, 3'd0, 64'h1000, 64'h0, 64'h8877665544332211, 0, 1'b0, 8'h00, 64'h0, 64'h8877665544332211);
    add(3'd3, 3'd0, 64'h1002, 64'h0, 64'h8877665544332211, 0, 1'b0, 8'h00, 64'h0, 64'h0000000000004433);
    add(3'd4, 3'd0, 64'h1006, 64'h0, 64'h8877665544332211, 0, 1'b0, 8'h00, 64'h0, 64'h0000000000008877);
    add(3'd3, 3'd0, 64'h1006, 64'h0, 64'h8877665544332211, 0, 1'b0, 8'h00, 64'h0, 64'hFFFFFFFFFFFF8877);
    add(3'd0, 3'd2, 64'h2006, 64'h123456789ABCABCD, 64'h0, 0, 1'b0, 8'hC0, 64'hABCDABCDABCDABCD, 64'hFFFFFFFFFFFF8877);
    add(3'd0, 3'd1, 64'h2003, 64'h000000000000005A, 64'h0, 0, 1'b0, 8'h08, 64'h5A5A5A5A5A5A5A5A, 64'hFFFFFFFFFFFF8877);
    add(3'd0, 3'd3, 64'h2004, 64'h00000000DEADBEEF, 64'h0, 0, 1'b0, 8'hF0, 64'hDEADBEEFDEADBEEF, 64'hFFFFFFFFFFFF8877);
    add(3'd0, 3'd4, 64'h3000, 64'h0123456789ABCDEF, 64'h0, 3, 1'b0, 8'hFF, 64'h0123456789ABCDEF, 64'hFFFFFFFFFFFF8877);
    add(3'd6, 3'd0, 64'h1004, 64'h0, 64'h0, 0, 1'b1, 8'h00, 64'h0, 64'hFFFFFFFFFFFF8877);
    add(3'd1, 3'd1, 64'h1000, 64'h0, 64'h0, 0, 1'b1, 8'h00, 64'h0, 64'hFFFFFFFFFFFF8877);
    add(3'd7, 3'd0, 64'h1000, 64'h0, 64'h0, 0, 1'b1, 8'h00, 64'h0, 64'hFFFFFFFFFFFF8877);
    add(3'd0, 3'd5, 64'h1000, 64'h0, 64'h0, 0, 1'b1, 8'h00, 64'h0, 64'hFFFFFFFFFFFF8877);
    add(3'd5, 3'd0, 64'h1002, 64'h0, 64'h0, 0, 1'b1, 8'h00, 64'h0, 64'hFFFFFFFFFFFF8877);
    add(3'd0, 3'd2, 64'h2001, 64'h0, 64'h0, 0, 1'b1, 8'h00, 64'h0, 64'hFFFFFFFFFFFF8877);
    add(3'd2, 3'd0, 64'h1001, 64'h0, 64'h8877665544332211, 1, 1'b0, 8'h00, 64'h0, 64'h0000000000000022);
    add(3'd0, 3'd3, 64'h2000, 64'hFFFFFFFF00C0FFEE, 64'h0, 0, 1'b0, 8'h0F, 64'h00C0FFEE00C0FFEE, 64'h0000000000000022);
    add(3'd5, 3'd0, 64'h1000, 64'h0, 64'h000000007FFFFFFF, 2, 1'b0, 8'h00, 64'h0, 64'h000000007FFFFFFF);

    rst = 1'b1;
    idle_inputs();
    addr = '0; wdata = '0; mem_ready = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_mem_addr", mem_addr, 64'd0);
    chk("rst_mem_wdata", mem_wdata, 64'd0);
    chk("rst_mem_wstrb", 64'(mem_wstrb), 64'd0);
    chk("rst_rdata", rdata, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset during REQ abandons the access
    req_valid  = 1'b1;
    dm_rd_ctrl = 3'd1;
    addr       = 64'h0;
    mem_ready  = 1'b0;
    #1;
    @(posedge clk); #1;
    idle_inputs();
    chk("mid_req_active", 64'(mem_req), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_req", 64'(mem_req), 64'd0);
    chk("mid_rst_stall", 64'(stall), 64'd0);
    chk("mid_rst_rdata", rdata, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    mem_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("mid_rst_no_done", 64'(done), 64'd0);
      chk("mid_rst_idle_req", 64'(mem_req), 64'd0);
      @(posedge clk); #1;
    end
    mem_ready = 1'b0;
    begin
      vec_t v;
      v.rd = 3'd1; v.wr = 3'd0; v.a = 64'h0; v.wd = 64'h0;
      v.mrd = 64'h00000000000000F0; v.waits = 0; v.e_err = 1'b0;
      v.e_addr = 64'h0; v.e_strb = 8'h00; v.e_wdata = 64'h0;
      v.e_rdata = 64'hFFFFFFFFFFFFFFF0;
      run_vec(v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
